// File: rtl/spi_cmd_pkg.sv
// Shared types and constants for the SPI command decoder: opcodes, FSM states
// and the per-opcode frame lengths fed back to the SPI receive buffer.
package spi_cmd_pkg;

    localparam int ADDR_W_DEF = 17;

    typedef enum logic [2:0] {
        WRITE_AT   = 3'b000,
        READ_AT    = 3'b001,
        READ_NEXT  = 3'b010,
        WRITE_NEXT = 3'b011
    } opcode_t;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DECODE = 2'd1,
        REQ    = 2'd2
    } state_t;

    localparam logic [2:0] LEN_WRITE_AT   = 3'd4;
    localparam logic [2:0] LEN_READ_AT    = 3'd3;
    localparam logic [2:0] LEN_READ_NEXT  = 3'd1;
    localparam logic [2:0] LEN_WRITE_NEXT = 3'd2;
    localparam logic [2:0] LEN_ILLEGAL    = 3'd1;

    // Illegal opcodes still report one byte so the buffer never waits on a zero-length frame.
    function automatic logic [2:0] frame_length(input logic [2:0] op);
        case (op)
            WRITE_AT:   return LEN_WRITE_AT;
            READ_AT:    return LEN_READ_AT;
            READ_NEXT:  return LEN_READ_NEXT;
            WRITE_NEXT: return LEN_WRITE_NEXT;
            default:    return LEN_ILLEGAL;
        endcase
    endfunction

endpackage

// File: rtl/sync2.sv
// Generic two-flop synchronizer for a single-bit level crossing into clk.
// Latency: two clk edges; no backpressure.
module sync2 (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/spi_cmd_decoder.sv
// Turns a completed SPI frame into one memory bus request; bus_pending rises three
// edges after the synchronized start and holds until the arbiter strobes bus_done.
module spi_cmd_decoder
    import spi_cmd_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              spi_valid,
    input  logic [7:0]        rx0,
    input  logic [7:0]        rx1,
    input  logic [7:0]        rx2,
    input  logic [7:0]        rx3,
    output logic [2:0]        length,
    output logic [7:0]        tx0,
    output logic              bus_pending,
    output logic              bus_rw_n,
    output logic [ADDR_W-1:0] bus_addr,
    output logic [7:0]        bus_wr_data,
    input  logic [7:0]        bus_rd_data,
    input  logic              bus_done,
    output logic              err_opcode,
    output logic              err_overrun
);

    logic   valid_sync;
    logic   valid_prev;
    logic   start;
    state_t state;
    state_t state_nxt;

    logic [2:0] snap_op;
    logic       snap_a16;
    logic [7:0] snap1;
    logic [7:0] snap2;
    logic [7:0] snap3;
    logic       snap_legal;

    sync2 u_valid_sync (
        .clk   (clk),
        .reset (reset),
        .d     (spi_valid),
        .q     (valid_sync)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) valid_prev <= 1'b0;
        else       valid_prev <= valid_sync;
    end

    assign start      = valid_sync & ~valid_prev;
    assign length     = frame_length(rx0[7:5]);
    assign snap_legal = ~snap_op[2];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = DECODE;
            DECODE:  state_nxt = snap_legal ? REQ : IDLE;
            REQ:     if (bus_done) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    assign bus_pending = (state == REQ);

    // Only the opcode, A16 and the three payload bytes are ever consumed from the frame.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            snap_op  <= 3'd0;
            snap_a16 <= 1'b0;
            snap1    <= 8'd0;
            snap2    <= 8'd0;
            snap3    <= 8'd0;
        end else if (start && state == IDLE) begin
            snap_op  <= rx0[7:5];
            snap_a16 <= rx0[0];
            snap1    <= rx1;
            snap2    <= rx2;
            snap3    <= rx3;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bus_rw_n    <= 1'b1;
            bus_addr    <= '0;
            bus_wr_data <= 8'd0;
            tx0         <= 8'd0;
            err_opcode  <= 1'b0;
            err_overrun <= 1'b0;
        end else begin
            if (start && state != IDLE)
                err_overrun <= 1'b1;

            if (state == DECODE) begin
                case (snap_op)
                    WRITE_AT: begin
                        bus_rw_n    <= 1'b0;
                        bus_wr_data <= snap1;
                        bus_addr    <= ADDR_W'({snap_a16, snap2, snap3});
                    end
                    READ_AT: begin
                        bus_rw_n <= 1'b1;
                        bus_addr <= ADDR_W'({snap_a16, snap1, snap2});
                    end
                    READ_NEXT: begin
                        bus_rw_n <= 1'b1;
                        bus_addr <= bus_addr + ADDR_W'(1);
                    end
                    WRITE_NEXT: begin
                        bus_rw_n    <= 1'b0;
                        bus_wr_data <= snap1;
                        bus_addr    <= bus_addr + ADDR_W'(1);
                    end
                    default: err_opcode <= 1'b1;
                endcase
            end

            if (state == REQ && bus_done && bus_rw_n)
                tx0 <= bus_rd_data;
        end
    end

endmodule

// File: tb/tb_spi_cmd_decoder.sv
// Directed frames against a transaction-level model of the decoder, checked every cycle.
module tb_spi_cmd_decoder;

    localparam int AW = 17;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          spi_valid = 1'b0;
    logic [7:0]    rx0 = 8'd0, rx1 = 8'd0, rx2 = 8'd0, rx3 = 8'd0;
    logic [2:0]    length;
    logic [7:0]    tx0;
    logic          bus_pending;
    logic          bus_rw_n;
    logic [AW-1:0] bus_addr;
    logic [7:0]    bus_wr_data;
    logic [7:0]    bus_rd_data = 8'd0;
    logic          bus_done = 1'b0;
    logic          err_opcode;
    logic          err_overrun;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    spi_cmd_decoder #(.ADDR_W(AW)) dut (
        .clk         (clk),
        .reset       (reset),
        .spi_valid   (spi_valid),
        .rx0         (rx0),
        .rx1         (rx1),
        .rx2         (rx2),
        .rx3         (rx3),
        .length      (length),
        .tx0         (tx0),
        .bus_pending (bus_pending),
        .bus_rw_n    (bus_rw_n),
        .bus_addr    (bus_addr),
        .bus_wr_data (bus_wr_data),
        .bus_rd_data (bus_rd_data),
        .bus_done    (bus_done),
        .err_opcode  (err_opcode),
        .err_overrun (err_overrun)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [2:0] exp_len(input logic [7:0] b0);
        case (b0[7:5])
            3'd0:    return 3'd4;
            3'd1:    return 3'd3;
            3'd3:    return 3'd2;
            default: return 3'd1;
        endcase
    endfunction

    // Transaction model: a frame is taken two edges after the sync first sees it,
    // turned into a bus request one edge later, and retired by bus_done.
    bit            m_pend = 0, m_rw_n = 1, m_err_op = 0, m_err_ov = 0, m_busy = 0;
    logic [AW-1:0] m_addr = '0;
    logic [7:0]    m_wr = 8'd0, m_tx0 = 8'd0;
    logic [7:0]    f0 = 8'd0, f1 = 8'd0, f2 = 8'd0, f3 = 8'd0;
    bit            v1 = 0, v2 = 0, v3 = 0;
    int            edge_n = 0, decode_at = -1;

    initial forever begin
        bit st, was_busy;
        @(posedge clk or posedge reset);
        if (reset) begin
            m_pend = 0; m_rw_n = 1; m_err_op = 0; m_err_ov = 0; m_busy = 0;
            m_addr = '0; m_wr = 8'd0; m_tx0 = 8'd0;
            v1 = 0; v2 = 0; v3 = 0; decode_at = -1;
        end else begin
            edge_n++;
            st = v2 & ~v3;
            was_busy = m_busy;
            if (m_pend && bus_done) begin
                if (m_rw_n) m_tx0 = bus_rd_data;
                m_pend = 0;
                m_busy = 0;
            end
            if (decode_at == edge_n) begin
                decode_at = -1;
                case (f0[7:5])
                    3'd0: begin m_rw_n = 0; m_wr = f1; m_addr = {f0[0], f2, f3}; m_pend = 1; end
                    3'd1: begin m_rw_n = 1; m_addr = {f0[0], f1, f2}; m_pend = 1; end
                    3'd2: begin m_rw_n = 1; m_addr = m_addr + 1'b1; m_pend = 1; end
                    3'd3: begin m_rw_n = 0; m_wr = f1; m_addr = m_addr + 1'b1; m_pend = 1; end
                    default: begin m_err_op = 1; m_busy = 0; end
                endcase
            end
            if (st) begin
                if (was_busy) m_err_ov = 1;
                else begin
                    f0 = rx0; f1 = rx1; f2 = rx2; f3 = rx3;
                    m_busy = 1;
                    decode_at = edge_n + 1;
                end
            end
            v3 = v2; v2 = v1; v1 = spi_valid;
        end
    end

    always @(negedge clk) begin
        check("bus_pending", 32'(bus_pending), 32'(m_pend));
        check("bus_rw_n", 32'(bus_rw_n), 32'(m_rw_n));
        check("bus_addr", 32'(bus_addr), 32'(m_addr));
        check("bus_wr_data", 32'(bus_wr_data), 32'(m_wr));
        check("tx0", 32'(tx0), 32'(m_tx0));
        check("err_opcode", 32'(err_opcode), 32'(m_err_op));
        check("err_overrun", 32'(err_overrun), 32'(m_err_ov));
        check("length", 32'(length), 32'(exp_len(rx0)));
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic raise(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2, input logic [7:0] b3);
        rx0 = b0; rx1 = b1; rx2 = b2; rx3 = b3;
        spi_valid = 1'b1;
    endtask

    task automatic wait_pend(output int n);
        n = 0;
        for (int i = 1; i <= 8; i++) begin
            tick(1);
            if (bus_pending) begin
                n = i;
                break;
            end
        end
    endtask

    task automatic complete(input logic [7:0] rd);
        bus_rd_data = rd;
        bus_done = 1'b1;
        tick(1);
        bus_done = 1'b0;
    endtask

    task automatic lower();
        spi_valid = 1'b0;
        tick(4);
    endtask

    initial begin
        int n;
        #1 reset = 1'b1;
        tick(2);
        check("rst_pending", 32'(bus_pending), 32'd0);
        check("rst_rw_n", 32'(bus_rw_n), 32'd1);
        check("rst_addr", 32'(bus_addr), 32'd0);
        check("rst_tx0", 32'(tx0), 32'd0);
        reset = 1'b0;
        tick(2);

        raise(8'h01, 8'h5A, 8'h80, 8'h00);
        wait_pend(n);
        check("write_at_rise_edges", 32'(n), 32'd4);
        check("write_at_len", 32'(length), 32'd4);
        check("write_at_addr", 32'(bus_addr), 32'h18000);
        check("write_at_rw_n", 32'(bus_rw_n), 32'd0);
        check("write_at_data", 32'(bus_wr_data), 32'h5A);
        complete(8'hEE);
        check("write_at_pend_fall", 32'(bus_pending), 32'd0);
        check("write_at_tx0_kept", 32'(tx0), 32'd0);
        lower();

        raise(8'h20, 8'h12, 8'h34, 8'h00);
        wait_pend(n);
        check("read_at_len", 32'(length), 32'd3);
        check("read_at_addr", 32'(bus_addr), 32'h01234);
        check("read_at_rw_n", 32'(bus_rw_n), 32'd1);
        complete(8'hC3);
        check("read_at_tx0", 32'(tx0), 32'hC3);
        lower();

        raise(8'h21, 8'hFF, 8'hFF, 8'h00);
        wait_pend(n);
        check("read_at_top_addr", 32'(bus_addr), 32'h1FFFF);
        complete(8'h11);
        lower();

        raise(8'h40, 8'h00, 8'h00, 8'h00);
        wait_pend(n);
        check("read_next_len", 32'(length), 32'd1);
        check("read_next_wrap", 32'(bus_addr), 32'h00000);
        complete(8'h22);
        check("read_next_tx0", 32'(tx0), 32'h22);
        lower();

        raise(8'h60, 8'h77, 8'h00, 8'h00);
        wait_pend(n);
        check("write_next_len", 32'(length), 32'd2);
        check("write_next_addr", 32'(bus_addr), 32'h00001);
        check("write_next_data", 32'(bus_wr_data), 32'h77);
        complete(8'h99);
        check("write_next_tx0_kept", 32'(tx0), 32'h22);
        lower();

        raise(8'hE0, 8'h00, 8'h00, 8'h00);
        wait_pend(n);
        check("illegal_no_req", 32'(n), 32'd0);
        check("illegal_err", 32'(err_opcode), 32'd1);
        check("illegal_len", 32'(length), 32'd1);
        check("illegal_addr_kept", 32'(bus_addr), 32'h00001);
        lower();

        raise(8'h20, 8'hAB, 8'hCD, 8'h00);
        wait_pend(n);
        check("overrun_first_rise", 32'(n), 32'd4);
        spi_valid = 1'b0;
        tick(3);
        raise(8'h01, 8'h11, 8'h22, 8'h33);
        tick(4);
        check("overrun_err", 32'(err_overrun), 32'd1);
        check("overrun_still_pend", 32'(bus_pending), 32'd1);
        check("overrun_addr_held", 32'(bus_addr), 32'h0ABCD);
        check("overrun_rw_held", 32'(bus_rw_n), 32'd1);
        complete(8'h5E);
        check("overrun_tx0", 32'(tx0), 32'h5E);
        lower();

        bus_rd_data = 8'h99;
        bus_done = 1'b1;
        tick(1);
        bus_done = 1'b0;
        tick(1);
        check("stray_done_tx0", 32'(tx0), 32'h5E);

        raise(8'h00, 8'hAA, 8'h00, 8'h10);
        wait_pend(n);
        check("rst_mid_rise", 32'(n), 32'd4);
        #3 reset = 1'b1;
        #1;
        check("rst_mid_pending", 32'(bus_pending), 32'd0);
        check("rst_mid_rw_n", 32'(bus_rw_n), 32'd1);
        check("rst_mid_addr", 32'(bus_addr), 32'd0);
        check("rst_mid_data", 32'(bus_wr_data), 32'd0);
        check("rst_mid_tx0", 32'(tx0), 32'd0);
        check("rst_mid_errs", 32'({err_opcode, err_overrun}), 32'd0);
        spi_valid = 1'b0;
        tick(2);
        reset = 1'b0;
        tick(2);

        raise(8'h20, 8'h00, 8'h05, 8'h00);
        wait_pend(n);
        check("post_rst_rise", 32'(n), 32'd4);
        check("post_rst_addr", 32'(bus_addr), 32'h00005);
        complete(8'h42);
        check("post_rst_tx0", 32'(tx0), 32'h42);
        lower();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/spi_cmd_decoder.md
# spi_cmd_decoder

Decodes the byte frame held by the SPI receive buffer into one memory bus transaction in the system clock domain. It sits directly downstream of the SPI buffer:
- It consumes the buffer's `rx[0..3]` bytes and its `valid` flag.
- It feeds back the expected frame `length` and the `tx[0]` read-back byte.
- It drives a request/done handshake toward the bus arbiter.

## Interface
Parameters:
- `ADDR_W`, 17: bus address width. Bit 16 is carried in the command byte.

Ports:
- `clk`  in  1  system clock.
- `reset`  in  1  reset, asynchronous, active-high.
- `spi_valid`  in  1  frame-complete flag from the SPI buffer. Asynchronous to `clk`.
- `rx0`..`rx3`  in  8 each  received frame bytes. Stable while `spi_valid` is high.
- `length`  out  3  expected byte count for the frame, decoded combinationally from `rx0`.
- `tx0`  out  8  last read result, returned as byte 0 of the next frame.
- `bus_pending`  out  1  bus request.
- `bus_rw_n`  out  1  1 = read, 0 = write.
- `bus_addr`  out  ADDR_W  transaction address.
- `bus_wr_data`  out  8  write data.
- `bus_rd_data`  in  8  read data. Valid in the cycle `bus_done` is high.
- `bus_done`  in  1  single-cycle completion strobe from the arbiter.
- `err_opcode`  out  1  sticky: illegal opcode received.
- `err_overrun`  out  1  sticky: frame arrived while busy.

## Operation
Opcode is `rx0[7:5]`. `A16` is `rx0[0]`.
- 000 WRITE_AT: `length` = 4.
  - Data = `rx1`, addr = {`A16`, `rx2`, `rx3`}.
- 001 READ_AT: `length` = 3.
  - Addr = {`A16`, `rx1`, `rx2`}.
- 010 READ_NEXT: `length` = 1.
  - Addr = previous `bus_addr` + 1, wrapping modulo 2^ADDR_W.
- 011 WRITE_NEXT: `length` = 2.
  - Data = `rx1`, addr = previous + 1 with the same wrap.
- 100–111: illegal. `length` = 1, no bus cycle, `err_opcode` set.
- `length` is never 0.

FSM states and transitions:
- IDLE → DECODE on `start`.
- DECODE → REQ for legal opcodes. DECODE → IDLE for illegal opcodes.
- REQ → IDLE on `bus_done`.

Synchronization:
- `spi_valid` passes through a 2-flop synchronizer plus an edge register.
- `start` = sync2 & ~sync3.

Capture and request:
- On `start` in IDLE, `rx0`..`rx3` are snapshotted into internal registers.
- In DECODE, `bus_addr`, `bus_rw_n` and `bus_wr_data` are loaded from the snapshot.
- `bus_pending` is asserted while in REQ. Address, data and direction are held constant throughout REQ.
- On `bus_done` with a read, `bus_rd_data` is captured into `tx0`. `tx0` is unchanged by writes.

Boundary conditions:
- `start` in any state other than IDLE: the frame is dropped and `err_overrun` is set. The FSM is unaffected.
- Reset mid-REQ: `bus_pending` deasserts immediately and the FSM returns to IDLE. The in-flight transaction is abandoned.
- `bus_done` outside REQ: ignored.
- Both error flags clear only on reset.

Reset values:
- `bus_pending` 0, `bus_rw_n` 1, `bus_addr` 0, `bus_wr_data` 0.
- `tx0` 0, `err_opcode` 0, `err_overrun` 0.
- FSM IDLE, synchronizer flops 0.

## Timing
- Edge k is the first `clk` edge at which sync1 samples `spi_valid` = 1.
- `start` is high during the cycle after edge k+1.
- DECODE is entered after edge k+2. REQ is entered, with `bus_pending` = 1, after edge k+3.
- Bus fields are valid no later than the edge at which `bus_pending` rises.
- If `bus_done` is sampled high at edge m:
  - `bus_pending` = 0 and `tx0` is updated after edge m.
  - IDLE is entered after edge m.
- Minimum spacing between frames: 5 `clk` cycles plus the arbiter latency.
- `spi_valid` must stay high for at least 3 `clk` periods to be seen.

## Structure
- Package `spi_cmd_pkg`:
  - opcode enum (WRITE_AT, READ_AT, READ_NEXT, WRITE_NEXT)
  - FSM state enum (IDLE, DECODE, REQ)
  - per-opcode length constants
  - the `ADDR_W` default
- Sub-module `sync2`: generic 2-flop synchronizer with asynchronous reset. Reused for other cross-domain strobes.

## Test plan
- WRITE_AT: `rx` = 01h, 5Ah, 80h, 00h → `bus_addr` = 18000h, `bus_rw_n` = 0, `bus_wr_data` = 5Ah. `bus_pending` rises 4 edges after sync and falls after `bus_done`.
- READ_AT 20h, 12h, 34h with `bus_rd_data` = C3h at `bus_done` → `bus_addr` = 01234h, `tx0` = C3h.
- READ_NEXT from `bus_addr` = 1FFFFh → address wraps to 00000h. `length` = 1 when `rx0` = 40h.
- Illegal `rx0` = E0h → no `bus_pending`, `err_opcode` = 1, `length` = 1.
- Second `spi_valid` edge while in REQ → dropped and `err_overrun` = 1. The original transaction completes unchanged.
- Assert `reset` while `bus_pending` = 1 → all outputs return to reset values immediately, without waiting for `clk`. The next frame then processes normally.
